// File: rtl/fnn_score_unit.sv
// Scoreboard for the FNN output stream: tallies matches per sample and divides out accuracy in percent.
// Optional per-class hit counters are enabled by defining PER_CLASS_STATS_EN.
module fnn_score_unit #(
    parameter int CNT_W       = 10,
    parameter int CLASS_W     = 4,
    parameter int NUM_CLASSES = 10,
    parameter int PCT_SCALE   = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   counter,
    input  logic [CLASS_W-1:0] pred,
    input  logic [CLASS_W-1:0] label,
    input  logic               done,
`ifdef PER_CLASS_STATS_EN
    input  logic [CLASS_W-1:0] class_sel,
    output logic [CNT_W-1:0]   class_hits,
`endif
    output logic [CNT_W-1:0]   tp_count,
    output logic [CNT_W-1:0]   total_count,
    output logic [6:0]         accuracy,
    output logic               acc_valid,
    output logic               busy,
    output logic               mismatch
);

    localparam int DW = CNT_W + 7;
    localparam int SW = $clog2(DW + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {COLLECT, DIVIDE, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter_q;
    logic             done_q;
    logic [DW-1:0]    quo;
    logic [CNT_W-1:0] rem;
    logic [SW-1:0]    step;

    logic             ev;
    logic             hit;
    logic             done_rise;
    logic [CNT_W:0]   trial;

    assign ev        = (state == COLLECT) && (counter != counter_q);
    assign hit       = (pred == label) && (int'(label) < NUM_CLASSES);
    assign done_rise = done & ~done_q;
    assign trial     = {rem, quo[DW-1]};

    // step counts DW+1 (load), DW..1 (quotient bits, MSB first), then 0 (publish)
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= COLLECT;
            counter_q   <= counter;
            done_q      <= 1'b0;
            quo         <= '0;
            rem         <= '0;
            step        <= '0;
            tp_count    <= '0;
            total_count <= '0;
            accuracy    <= '0;
            acc_valid   <= 1'b0;
            busy        <= 1'b0;
            mismatch    <= 1'b0;
        end else begin
            counter_q <= counter;
            done_q    <= done;
            mismatch  <= 1'b0;
            case (state)
                COLLECT: begin
                    if (ev) begin
                        if (total_count != CNT_MAX)
                            total_count <= total_count + 1'b1;
                        if (hit) begin
                            if (tp_count != CNT_MAX)
                                tp_count <= tp_count + 1'b1;
                        end else begin
                            mismatch <= 1'b1;
                        end
                    end
                    if (done_rise) begin
                        state <= DIVIDE;
                        step  <= SW'(DW + 1);
                        busy  <= ev || (total_count != '0);
                    end
                end
                DIVIDE: begin
                    if (step == SW'(DW + 1)) begin
                        if (total_count == '0) begin
                            accuracy  <= '0;
                            acc_valid <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            quo  <= DW'(tp_count) * DW'(PCT_SCALE);
                            rem  <= '0;
                            step <= SW'(DW);
                        end
                    end else if (step != '0) begin
                        if (trial >= {1'b0, total_count}) begin
                            rem <= CNT_W'(trial - {1'b0, total_count});
                            quo <= {quo[DW-2:0], 1'b1};
                        end else begin
                            rem <= trial[CNT_W-1:0];
                            quo <= {quo[DW-2:0], 1'b0};
                        end
                        step <= step - 1'b1;
                    end else begin
                        accuracy  <= quo[6:0];
                        acc_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PER_CLASS_STATS_EN
    logic [CNT_W-1:0] hits [NUM_CLASSES];

    // hit is only true for in-range labels, so hits[label] never goes out of bounds
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                hits[i] <= '0;
            class_hits <= '0;
        end else begin
            if (ev && hit && hits[label] != CNT_MAX)
                hits[label] <= hits[label] + 1'b1;
            class_hits <= (int'(class_sel) < NUM_CLASSES) ? hits[class_sel] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_fnn_score_unit.sv
// Directed self-checking bench for fnn_score_unit; hand-computed expectations checked with immediate assertions.
module tb_fnn_score_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] counter;
    logic [3:0] pred;
    logic [3:0] label;
    logic       done;
    logic [9:0] tp_count;
    logic [9:0] total_count;
    logic [6:0] accuracy;
    logic       acc_valid;
    logic       busy;
    logic       mismatch;
`ifdef PER_CLASS_STATS_EN
    logic [3:0] class_sel;
    logic [9:0] class_hits;
`endif

    int checks = 0;
    int fails  = 0;

    fnn_score_unit dut (
        .clk(clk),
        .rst(rst),
        .counter(counter),
        .pred(pred),
        .label(label),
        .done(done),
`ifdef PER_CLASS_STATS_EN
        .class_sel(class_sel),
        .class_hits(class_hits),
`endif
        .tp_count(tp_count),
        .total_count(total_count),
        .accuracy(accuracy),
        .acc_valid(acc_valid),
        .busy(busy),
        .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] c, input logic [3:0] p, input logic [3:0] l, input logic d);
        counter = c;
        pred    = p;
        label   = l;
        done    = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one sample per two cycles; the mismatch pulse is visible right after the scoring edge
    task automatic scoreSample(input string tag, input logic [9:0] c, input logic [3:0] p, input logic [3:0] l, input logic expMis);
        applyStimulus(c, p, l, 1'b0);
        tick(1);
        checkOutput({tag, "_mis"}, 32'(mismatch), 32'(expMis));
        tick(1);
    endtask

    task automatic doReset;
        rst  = 1'b0;
        done = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic waitValid(input string tag, input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            if (acc_valid) break;
            tick(1);
        end
        checkOutput({tag, "_valid"}, 32'(acc_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic sawBusy;
        rst = 1'b0;
        applyStimulus(10'd0, 4'd0, 4'd0, 1'b0);
`ifdef PER_CLASS_STATS_EN
        class_sel = 4'd0;
`endif
        // reset hold with a moving counter
        tick(1);
        counter = 10'd2;
        tick(1);
        counter = 10'd5;
        tick(1);
        checkOutput("rst_tp", 32'(tp_count), 32'd0);
        checkOutput("rst_total", 32'(total_count), 32'd0);
        checkOutput("rst_acc", 32'(accuracy), 32'd0);
        checkOutput("rst_valid", 32'(acc_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mis", 32'(mismatch), 32'd0);
        rst = 1'b1;
        tick(1);
        checkOutput("post_rst_total", 32'(total_count), 32'd0);
        checkOutput("post_rst_mis", 32'(mismatch), 32'd0);

        // basic scoring: 3 of 4 match -> 75
        scoreSample("b1", 10'd1, 4'd3, 4'd3, 1'b0);
        scoreSample("b2", 10'd2, 4'd7, 4'd2, 1'b1);
        checkOutput("b2_pulse_end", 32'(mismatch), 32'd0);
        scoreSample("b3", 10'd3, 4'd0, 4'd0, 1'b0);
        scoreSample("b4", 10'd4, 4'd9, 4'd9, 1'b0);
        checkOutput("b_tp", 32'(tp_count), 32'd3);
        checkOutput("b_total", 32'(total_count), 32'd4);
        done = 1'b1;
        tick(2);
        checkOutput("b_busy", 32'(busy), 32'd1);
        // done is seen at the first edge; load + 17 bits + publish puts acc_valid 19 edges after it
        tick(17);
        checkOutput("b_valid_early", 32'(acc_valid), 32'd0);
        tick(1);
        checkOutput("b_valid", 32'(acc_valid), 32'd1);
        checkOutput("b_acc", 32'(accuracy), 32'd75);
        checkOutput("b_busy_end", 32'(busy), 32'd0);
        applyStimulus(10'd9, 4'd1, 4'd1, 1'b0);
        tick(2);
        checkOutput("b_frozen_total", 32'(total_count), 32'd4);
        checkOutput("b_frozen_tp", 32'(tp_count), 32'd3);
        checkOutput("b_held_valid", 32'(acc_valid), 32'd1);

        // 1 of 3 with an out-of-range class -> 33
        doReset;
        scoreSample("r1", 10'd10, 4'd12, 4'd12, 1'b1);
        scoreSample("r2", 10'd11, 4'd5, 4'd5, 1'b0);
        scoreSample("r3", 10'd12, 4'd1, 4'd0, 1'b1);
        done = 1'b1;
        waitValid("r", 40);
        checkOutput("r_acc", 32'(accuracy), 32'd33);
        checkOutput("r_tp", 32'(tp_count), 32'd1);

        // done with no samples -> 0 without ever raising busy
        doReset;
        done = 1'b1;
        sawBusy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (busy) sawBusy = 1'b1;
            if (acc_valid) break;
        end
        checkOutput("z_valid", 32'(acc_valid), 32'd1);
        checkOutput("z_acc", 32'(accuracy), 32'd0);
        checkOutput("z_busy", 32'(sawBusy), 32'd0);

        // sample and done rise on the same edge -> 1 of 2 -> 50
        doReset;
        scoreSample("s1", 10'd13, 4'd1, 4'd2, 1'b1);
        applyStimulus(10'd14, 4'd4, 4'd4, 1'b1);
        tick(1);
        checkOutput("s_total", 32'(total_count), 32'd2);
        checkOutput("s_tp", 32'(tp_count), 32'd1);
        waitValid("s", 40);
        checkOutput("s_acc", 32'(accuracy), 32'd50);

        // reset aborts an in-flight divide
        doReset;
        scoreSample("m1", 10'd15, 4'd3, 4'd3, 1'b0);
        done = 1'b1;
        tick(6);
        checkOutput("m_busy", 32'(busy), 32'd1);
        rst  = 1'b0;
        done = 1'b0;
        tick(1);
        checkOutput("m_rst_busy", 32'(busy), 32'd0);
        checkOutput("m_rst_valid", 32'(acc_valid), 32'd0);
        checkOutput("m_rst_tp", 32'(tp_count), 32'd0);
        checkOutput("m_rst_total", 32'(total_count), 32'd0);
        rst = 1'b1;
        tick(1);
        scoreSample("m2", 10'd16, 4'd6, 4'd6, 1'b0);
        scoreSample("m3", 10'd17, 4'd8, 4'd8, 1'b0);
        done = 1'b1;
        waitValid("m", 40);
        checkOutput("m_acc", 32'(accuracy), 32'd100);

        // 1030 back-to-back matches saturate both tallies at 1023
        doReset;
        pred  = 4'd1;
        label = 4'd1;
        for (int i = 0; i < 1030; i++) begin
            counter = counter + 10'd1;
            tick(1);
        end
        checkOutput("sat_total", 32'(total_count), 32'd1023);
        checkOutput("sat_tp", 32'(tp_count), 32'd1023);
        done = 1'b1;
        waitValid("sat", 40);
        checkOutput("sat_acc", 32'(accuracy), 32'd100);

`ifdef PER_CLASS_STATS_EN
        doReset;
        scoreSample("c1", 10'd18, 4'd2, 4'd2, 1'b0);
        scoreSample("c2", 10'd19, 4'd2, 4'd2, 1'b0);
        scoreSample("c3", 10'd20, 4'd5, 4'd5, 1'b0);
        scoreSample("c4", 10'd21, 4'd3, 4'd2, 1'b1);
        class_sel = 4'd2;
        tick(1);
        checkOutput("c_hits2", 32'(class_hits), 32'd2);
        class_sel = 4'd5;
        tick(1);
        checkOutput("c_hits5", 32'(class_hits), 32'd1);
        class_sel = 4'd12;
        tick(1);
        checkOutput("c_hits12", 32'(class_hits), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
